// File: rtl/eth_pkg.sv
// Ethernet constants, RX state encoding and the reflected CRC-32 dibit step.
// Latency: none (declarations and a pure function only).
// Backpressure: not applicable.
package eth_pkg;

    localparam logic [1:0]  ETH_PREAMBLE_DIBIT = 2'b01;
    localparam logic [1:0]  ETH_SFD_DIBIT      = 2'b11;
    localparam int          ETH_HDR_BYTES      = 14;
    localparam int          ETH_FCS_BYTES      = 4;
    localparam int          ETH_MAC_BYTES      = 6;
    localparam logic [47:0] ETH_BROADCAST_MAC  = 48'hFFFF_FFFF_FFFF;
    localparam logic [31:0] CRC32_POLY_REFL    = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT         = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE      = 32'hDEBB_20E3;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        HEADER,
        PAYLOAD,
        FCS,
        DROP,
        WAIT_IDLE
    } rx_state_t;

    // Advance a reflected CRC-32 by one RMII dibit, bit 0 of the dibit first.
    function automatic logic [31:0] crc32_next_dibit(input logic [31:0] crc_in,
                                                     input logic [1:0]  dibit);
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 2; i++) begin
            if (c[0] ^ dibit[i]) begin
                c = (c >> 1) ^ CRC32_POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_dibit.sv
// Running reflected CRC-32 over a 2-bit-per-cycle stream (shared with TX side).
// Latency: register reflects a dibit one cycle after it is presented with en=1.
// Backpressure: none; the caller gates en, clear has priority over en.
module crc32_dibit
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        en,
    input  logic [1:0]  dibit,
    output logic [31:0] crc
);

    logic [31:0] crc_next;

    assign crc_next = crc32_next_dibit(crc, dibit);

    // CRC state: preset on reset or clear, otherwise fold in each enabled dibit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc <= CRC32_INIT;
        end else if (clear) begin
            crc <= CRC32_INIT;
        end else if (en) begin
            crc <= crc_next;
        end
    end

endmodule

// File: rtl/rmii_packet_rx.sv
// RMII frame receiver: SFD detect, dest-MAC filter, header strip, payload to AXI-S words, FCS check.
// Latency: the tlast word is valid 2 cycles after the final FCS dibit is presented.
// Backpressure: one holding word plus one output word; a word that cannot move out is dropped and the frame flagged.
module rmii_packet_rx
    import eth_pkg::*;
#(
    parameter int          PACKET_PAYLOAD_WORDS = 128,
    parameter int          WORD_BYTES           = 4,
    parameter logic [47:0] OWN_MAC              = 48'h00_18_3E_01_EB_6E
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    crs_dv,
    input  logic [1:0]              rxd,
    input  logic                    rx_er,
    output logic [WORD_BYTES*8-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tuser,
    output logic [15:0]             frame_ok_count,
    output logic [15:0]             frame_err_count
);

    localparam int          WORD_W        = WORD_BYTES * 8;
    localparam int          PAYLOAD_BYTES = PACKET_PAYLOAD_WORDS * WORD_BYTES;
    localparam logic [15:0] DEST_LAST     = 16'(ETH_MAC_BYTES - 1);
    localparam logic [15:0] HDR_LAST      = 16'(ETH_HDR_BYTES - 1);
    localparam logic [15:0] PL_LAST       = 16'(PAYLOAD_BYTES - 1);
    localparam logic [15:0] FCS_LAST      = 16'(ETH_FCS_BYTES - 1);
    localparam logic [7:0]  WB_LAST       = 8'(WORD_BYTES - 1);

    rx_state_t state, state_nxt;

    // Byte and word assembly
    logic [1:0]        dcnt;
    logic [5:0]        dibit_sr;
    logic [7:0]        byte_now;
    logic [15:0]       byte_cnt;
    logic [7:0]        wbyte_cnt;
    logic [39:0]       dest_sr;
    logic [47:0]       dest_now;
    logic [WORD_W-9:0] word_sr;
    logic [WORD_W-1:0] word_now;

    // Word pipeline: one held word feeding one output register
    logic [WORD_W-1:0] hold_dat;
    logic              hold_vld;
    logic [WORD_W-1:0] out_dat;
    logic              out_vld;
    logic              out_last;
    logic              out_user;

    // Frame status
    logic        err;
    logic        judge;
    logic [15:0] ok_cnt;
    logic [15:0] err_cnt;
    logic [31:0] crc;

    // Per-cycle decode
    logic in_frame;
    logic sfd;
    logic byte_done;
    logic dest_match;
    logic last_hdr;
    logic last_pl;
    logic last_fcs;
    logic word_done;
    logic trunc;
    logic rx_err_now;
    logic crc_bad;
    logic fin;
    logic fin_err;
    logic move;
    logic can_load;
    logic load_out;
    logic ovf;
    logic crc_en;

    // The newest dibit lands in the top bits, completing the byte LSB-first.
    assign byte_now   = {rxd, dibit_sr};
    assign dest_now   = {dest_sr, byte_now};
    assign word_now   = {word_sr, byte_now};

    assign in_frame   = (state == HEADER) || (state == PAYLOAD) || (state == FCS);
    assign sfd        = (state == PREAMBLE) && crs_dv && (rxd == ETH_SFD_DIBIT);
    assign byte_done  = in_frame && crs_dv && (dcnt == 2'd3);
    assign dest_match = (dest_now == OWN_MAC) || (dest_now == ETH_BROADCAST_MAC);
    assign last_hdr   = (state == HEADER)  && byte_done && (byte_cnt == HDR_LAST);
    assign last_pl    = (state == PAYLOAD) && byte_done && (byte_cnt == PL_LAST);
    assign last_fcs   = (state == FCS)     && byte_done && (byte_cnt == FCS_LAST);
    assign word_done  = (state == PAYLOAD) && byte_done && (wbyte_cnt == WB_LAST);

    // Carrier loss inside the frame ends it on the spot with an error.
    assign trunc      = in_frame && !crs_dv;
    assign rx_err_now = in_frame && rx_er;
    assign crc_bad    = (crc != CRC32_RESIDUE);
    assign crc_en     = in_frame && crs_dv;

    // judge is set the cycle after the last FCS dibit, when the CRC register is final.
    assign fin        = trunc || ((state == WAIT_IDLE) && judge);
    assign fin_err    = err || rx_err_now || trunc || crc_bad;

    // The held word leaves either when its successor completes or at frame end.
    assign move       = hold_vld && (word_done || fin);
    assign can_load   = !out_vld || m_axis_tready;
    assign load_out   = move && can_load;
    assign ovf        = move && !can_load;

    crc32_dibit u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (sfd),
        .en    (crc_en),
        .dibit (rxd),
        .crc   (crc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic for framing, filtering and end-of-frame.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (crs_dv && (rxd == ETH_PREAMBLE_DIBIT)) begin
                    state_nxt = PREAMBLE;
                end
            end
            PREAMBLE: begin
                if (!crs_dv) begin
                    state_nxt = IDLE;
                end else if (rxd == ETH_SFD_DIBIT) begin
                    state_nxt = HEADER;
                end else if (rxd != ETH_PREAMBLE_DIBIT) begin
                    state_nxt = IDLE;
                end
            end
            HEADER: begin
                if (!crs_dv) begin
                    state_nxt = IDLE;
                end else if (byte_done && (byte_cnt == DEST_LAST) && !dest_match) begin
                    state_nxt = DROP;
                end else if (last_hdr) begin
                    state_nxt = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (!crs_dv) begin
                    state_nxt = IDLE;
                end else if (last_pl) begin
                    state_nxt = FCS;
                end
            end
            FCS: begin
                if (!crs_dv) begin
                    state_nxt = IDLE;
                end else if (last_fcs) begin
                    state_nxt = WAIT_IDLE;
                end
            end
            DROP, WAIT_IDLE: begin
                if (!crs_dv) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Dibit/byte/word assembly, dest capture and per-frame error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dcnt      <= '0;
            dibit_sr  <= '0;
            byte_cnt  <= '0;
            wbyte_cnt <= '0;
            dest_sr   <= '0;
            word_sr   <= '0;
            err       <= 1'b0;
            judge     <= 1'b0;
        end else begin
            dibit_sr <= byte_now[7:2];
            judge    <= last_fcs;
            if (sfd) begin
                dcnt      <= '0;
                byte_cnt  <= '0;
                wbyte_cnt <= '0;
                err       <= 1'b0;
            end else begin
                if (crc_en) begin
                    dcnt <= dcnt + 2'd1;
                end
                if (byte_done) begin
                    byte_cnt <= (last_hdr || last_pl || last_fcs) ? 16'd0 : byte_cnt + 16'd1;
                end
                if ((state == HEADER) && byte_done) begin
                    dest_sr <= dest_now[39:0];
                end
                if ((state == PAYLOAD) && byte_done) begin
                    word_sr   <= word_now[WORD_W-9:0];
                    wbyte_cnt <= word_done ? 8'd0 : wbyte_cnt + 8'd1;
                end
                if (rx_err_now || ovf) begin
                    err <= 1'b1;
                end
            end
        end
    end

    // Holding and output registers; the output is only replaced when empty or accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_dat <= '0;
            hold_vld <= 1'b0;
            out_dat  <= '0;
            out_vld  <= 1'b0;
            out_last <= 1'b0;
            out_user <= 1'b0;
        end else begin
            if (word_done) begin
                hold_dat <= word_now;
                hold_vld <= 1'b1;
            end else if (fin) begin
                hold_vld <= 1'b0;
            end

            if (load_out) begin
                out_dat  <= hold_dat;
                out_vld  <= 1'b1;
                out_last <= fin;
                out_user <= fin && fin_err;
            end else if (out_vld && m_axis_tready) begin
                out_vld <= 1'b0;
            end
        end
    end

    // Frame verdict counters; a frame losing its last word to overflow counts as bad.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ok_cnt  <= '0;
            err_cnt <= '0;
        end else if (fin) begin
            if (fin_err || ovf) begin
                err_cnt <= err_cnt + 16'd1;
            end else begin
                ok_cnt <= ok_cnt + 16'd1;
            end
        end
    end

    assign m_axis_tdata    = out_dat;
    assign m_axis_tvalid   = out_vld;
    assign m_axis_tlast    = out_last;
    assign m_axis_tuser    = out_user;
    assign frame_ok_count  = ok_cnt;
    assign frame_err_count = err_cnt;

endmodule

// File: tb/tb_rmii_packet_rx.sv
// Scoreboard bench for rmii_packet_rx: directed frames in, expected words queued, monitor compares beats.
// Latency: not applicable.
// Backpressure: the sink stalls tready for a fixed window in one frame.
`timescale 1ns/1ps
module tb_rmii_packet_rx;

    localparam logic [47:0] OWN   = 48'h0018_3E01_EB6E;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] OTHER = 48'h0200_0000_0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        crs_dv;
    logic [1:0]  rxd;
    logic        rx_er;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic [15:0] frame_ok_count;
    logic [15:0] frame_err_count;

    always #10 clk = ~clk;

    rmii_packet_rx #(
        .PACKET_PAYLOAD_WORDS (128),
        .WORD_BYTES           (4),
        .OWN_MAC              (OWN)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .crs_dv          (crs_dv),
        .rxd             (rxd),
        .rx_er           (rx_er),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tuser    (m_axis_tuser),
        .frame_ok_count  (frame_ok_count),
        .frame_err_count (frame_err_count)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    logic [33:0] sb[$];
    logic [7:0]  fr[$];
    logic [7:0]  pl[512];
    int          stall_cnt = 0;
    int          exp_ok = 0;
    int          exp_err = 0;
    logic        stalled = 1'b0;
    logic [33:0] stall_val = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    // Monitor: hold-stability while stalled, and scoreboard compare on each accepted beat.
    always @(negedge clk) begin
        logic [33:0] cur;
        logic [33:0] exp;
        cur = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
        if (stalled && m_axis_tvalid) check("hold_stable", 64'(cur), 64'(stall_val));
        stalled   = m_axis_tvalid && !m_axis_tready;
        stall_val = cur;
        if (m_axis_tvalid && m_axis_tready) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL spurious_beat: got word %h last %b user %b, required no beat",
                         m_axis_tdata, m_axis_tlast, m_axis_tuser);
            end else begin
                exp = sb.pop_front();
                check("beat", 64'(cur), 64'(exp));
            end
        end
    end

    task automatic build_frame(input logic [47:0] dest, input int flip_byte);
        logic [31:0] c;
        logic [47:0] src;
        src = 48'h0211_2233_4455;
        fr.delete();
        for (int i = 5; i >= 0; i--) fr.push_back(dest[8*i +: 8]);
        for (int i = 5; i >= 0; i--) fr.push_back(src[8*i +: 8]);
        fr.push_back(8'h88);
        fr.push_back(8'hB5);
        for (int j = 0; j < 512; j++) fr.push_back(pl[j]);
        c = 32'hFFFF_FFFF;
        foreach (fr[i]) c = crc_byte(c, fr[i]);
        c = ~c;
        for (int i = 0; i < 4; i++) fr.push_back(c[8*i +: 8]);
        if (flip_byte >= 0) fr[14 + flip_byte] = fr[14 + flip_byte] ^ 8'h01;
    endtask

    task automatic push_words(input int n, input logic has_last, input logic user,
                              input int skip_a, input int skip_b, input int flip_byte);
        logic [31:0] w;
        logic [7:0]  x;
        for (int i = 0; i < n; i++) begin
            if (i != skip_a && i != skip_b) begin
                w = '0;
                for (int b = 0; b < 4; b++) begin
                    x = pl[4*i + b];
                    if (4*i + b == flip_byte) x = x ^ 8'h01;
                    w = {w[23:0], x};
                end
                sb.push_back({w, has_last && (i == n-1), has_last && (i == n-1) && user});
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int d = 0; d < 4; d++) begin
            crs_dv = 1'b1;
            rxd    = b[2*d +: 2];
            if (stall_cnt > 0) begin
                m_axis_tready = 1'b0;
                stall_cnt--;
            end else begin
                m_axis_tready = 1'b1;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input int trunc_after, input int stall_at, input int rst_after,
                              input int n_extra);
        int  pb;
        logic aborted;
        aborted = 1'b0;
        for (int k = 0; k < 7; k++) send_byte(8'h55);
        send_byte(8'hD5);
        for (int k = 0; k < fr.size(); k++) begin
            pb = k - 14;
            if (trunc_after >= 0 && pb == trunc_after) begin
                aborted = 1'b1;
                break;
            end
            if (rst_after >= 0 && pb == rst_after) begin
                rst_n = 1'b0; crs_dv = 1'b0; rxd = 2'b00;
                @(posedge clk); #1;
                rst_n = 1'b1;
                check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
                check("rst_ok_count", 64'(frame_ok_count), 64'd0);
                check("rst_err_count", 64'(frame_err_count), 64'd0);
                aborted = 1'b1;
                break;
            end
            if (stall_at >= 0 && pb == stall_at) stall_cnt = 40;
            send_byte(fr[k]);
        end
        if (!aborted) for (int e = 0; e < n_extra; e++) send_byte(8'hA5);
        crs_dv = 1'b0; rxd = 2'b00; m_axis_tready = 1'b1; stall_cnt = 0;
        repeat (12) begin @(posedge clk); #1; end
    endtask

    task automatic finish_test(input string name);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 3000) begin @(posedge clk); #1; t++; end
        check({name, "_drained"}, 64'(sb.size()), 64'd0);
        sb.delete();
        check({name, "_ok_count"}, 64'(frame_ok_count), 64'(exp_ok));
        check({name, "_err_count"}, 64'(frame_err_count), 64'(exp_err));
    endtask

    initial begin
        rst_n = 1'b0; crs_dv = 1'b0; rxd = 2'b00; rx_er = 1'b0; m_axis_tready = 1'b1;
        for (int j = 0; j < 512; j++) pl[j] = 8'(j);
        repeat (3) @(posedge clk);
        #1;
        check("reset_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("reset_tdata", 64'(m_axis_tdata), 64'd0);
        check("reset_tlast_tuser", 64'({m_axis_tlast, m_axis_tuser}), 64'd0);
        check("reset_ok_count", 64'(frame_ok_count), 64'd0);
        check("reset_err_count", 64'(frame_err_count), 64'd0);
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // Good unicast frame.
        build_frame(OWN, -1);
        push_words(128, 1'b1, 1'b0, -1, -1, -1);
        send_frame(-1, -1, -1, 0);
        exp_ok++;
        finish_test("good");

        // One payload bit flipped after FCS computed.
        build_frame(OWN, 100);
        push_words(128, 1'b1, 1'b1, -1, -1, 100);
        send_frame(-1, -1, -1, 0);
        exp_err++;
        finish_test("crc_err");

        // Foreign destination: nothing out, no counter change.
        build_frame(OTHER, -1);
        send_frame(-1, -1, -1, 0);
        finish_test("mac_drop");

        // Broadcast good frame with trailing bytes after the FCS.
        build_frame(BCAST, -1);
        push_words(128, 1'b1, 1'b0, -1, -1, -1);
        send_frame(-1, -1, -1, 2);
        exp_ok++;
        finish_test("bcast");

        // Carrier lost after 40 payload bytes.
        build_frame(OWN, -1);
        push_words(10, 1'b1, 1'b1, -1, -1, -1);
        send_frame(40, -1, -1, 0);
        exp_err++;
        finish_test("trunc");

        build_frame(OWN, -1);
        push_words(128, 1'b1, 1'b0, -1, -1, -1);
        send_frame(-1, -1, -1, 0);
        exp_ok++;
        finish_test("after_trunc");

        // tready low for 40 cycles from the start of word 20: words 19 and 20 are overrun.
        build_frame(OWN, -1);
        push_words(128, 1'b1, 1'b1, 19, 20, -1);
        send_frame(-1, 80, -1, 0);
        exp_err++;
        finish_test("overflow");

        // Reset after 20 payload bytes: words 0..3 have already left.
        build_frame(OWN, -1);
        push_words(4, 1'b0, 1'b0, -1, -1, -1);
        send_frame(-1, -1, 20, 0);
        exp_ok = 0;
        exp_err = 0;
        finish_test("reset");

        build_frame(OWN, -1);
        push_words(128, 1'b1, 1'b0, -1, -1, -1);
        send_frame(-1, -1, -1, 0);
        exp_ok++;
        finish_test("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rmii_packet_rx.md
Name: rmii_packet_rx

Overview:
- RMII receive path; the counterpart of the packet generator on the TX side.
- Samples RXD/CRS_DV on the 50 MHz Ethernet clock and detects preamble/SFD.
- Filters on destination MAC and strips the 14-byte header.
- Packs a fixed-length payload into big-endian words on an AXI-Stream master and verifies the FCS; the frame's last word carries tlast plus a tuser error flag.

Parameters:
- PACKET_PAYLOAD_WORDS, 128: payload words per frame (fixed length).
- WORD_BYTES, 4: bytes per output word.
- OWN_MAC, 48'H00_18_3E_01_EB_6E: accepted unicast destination; FF:FF:FF:FF:FF:FF is also accepted.

Ports:
- clk  in  1: RMII reference clock (50 MHz, eth_clk domain).
- rst_n  in  1: synchronous, active-low reset.
- crs_dv  in  1: RMII carrier sense / data valid.
- rxd  in  2: RMII receive dibit, LSB-first within each byte.
- rx_er  in  1: PHY receive error.
- m_axis_tdata  out  WORD_BYTES*8: payload word; the first received byte is in the MSBs.
- m_axis_tvalid  out  1: word valid.
- m_axis_tready  in  1: sink ready.
- m_axis_tlast  out  1: last word of the frame.
- m_axis_tuser  out  1: frame error; valid only with tlast.
- frame_ok_count  out  16: wrapping count of good frames.
- frame_err_count  out  16: wrapping count of bad frames, excluding MAC-filtered frames.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-low. While rst_n=0:
  - all outputs are 0, counters are 0, state is IDLE;
  - the holding and output registers are invalidated.
  - A frame in progress at reset is abandoned; no partial output appears after reset. The next frame needs a full preamble.
- Dibit assembly:
  - Byte bits are rxd[1:0] first, i.e. byte[1:0], then [3:2], [5:4], [7:6].
  - A 2-bit dibit counter is reset on SFD detection.
- FSM states: IDLE, PREAMBLE, HEADER, PAYLOAD, FCS, DROP, WAIT_IDLE.
  - IDLE: crs_dv=1 and rxd=01 -> PREAMBLE.
  - PREAMBLE:
    - rxd=01 stays.
    - rxd=11 -> HEADER (SFD; byte alignment starts on the next cycle).
    - Any other value, or crs_dv=0 -> IDLE. Not counted as an error.
  - HEADER: 14 bytes.
    - After byte 6, if dest != OWN_MAC and dest != broadcast -> DROP. Not counted.
    - After byte 14 -> PAYLOAD. Source MAC and ethertype are not checked.
  - PAYLOAD: PACKET_PAYLOAD_WORDS*WORD_BYTES bytes, then -> FCS.
  - FCS: 4 bytes. Judged 1 cycle after the last FCS dibit -> WAIT_IDLE.
  - DROP and WAIT_IDLE: wait until crs_dv=0 -> IDLE.
- CRC:
  - Reflected CRC-32, polynomial 0xEDB88320, init 0xFFFFFFFF, 2 bits per cycle LSB-first.
  - Covers destination MAC through FCS inclusive.
  - The frame is good iff the final CRC register = 32'hDEBB20E3.
- Word pipeline:
  - A completed word goes into a one-word holding register. The previous held word moves to the output register.
  - So every word except the last is emitted when its successor completes.
  - At frame end the held word moves to the output register with tlast=1 and tuser=error.
  - If no word is held, nothing is emitted; only the counter updates.
- Error sources: any one sets error for the frame.
  - rx_er=1 in HEADER, PAYLOAD or FCS.
  - crs_dv=0 before the FCS completes (truncated). Judged immediately.
  - CRC mismatch.
  - Output overflow.
- Overflow:
  - Occurs when the held word must move out while the output register is valid and tready=0.
  - The held word is discarded and error is set.
  - The output register is never overwritten while valid and not accepted.
- Handshake:
  - Standard AXI-S: tdata, tlast and tuser are stable while tvalid=1 and tready=0.
  - tvalid drops the cycle after acceptance unless a new word loads the same cycle.
- Counters: exactly one of frame_ok_count / frame_err_count increments per frame that passed the MAC filter. Both wrap at 16'hFFFF -> 0.
- Latency: the last word, with tlast, is valid 2 cycles after the final FCS dibit is sampled.
- Bytes after the FCS while crs_dv=1 are ignored and do not affect the verdict.

Decomposition:
- Shared package eth_pkg:
  - ETH_PREAMBLE_DIBIT=2'b01, ETH_SFD_DIBIT=2'b11;
  - ETH_HDR_BYTES=14, ETH_FCS_BYTES=4;
  - ETH_BROADCAST_MAC, CRC32_POLY_REFL=32'hEDB88320, CRC32_RESIDUE=32'hDEBB20E3;
  - rx_state_t enum.
- One sub-module: crc32_dibit, a combinational next-CRC function of (crc_in, dibit) plus its state register, with enable and clear. The TX side reuses it.

Test Plan:
- Good frame: 7x 0x55, 0xD5, dest=OWN_MAC, src, ethertype 0x88B5, 512 payload bytes 0x00..0xFF repeating, valid FCS, tready=1 -> 128 words; first word 32'h00010203; word 128 has tlast=1, tuser=0; frame_ok_count=1.
- Same frame with one payload bit flipped -> 128 words; last word has tuser=1; frame_err_count=1, frame_ok_count=0.
- dest=02:00:00:00:00:01 -> no tvalid at all; both counters unchanged. A broadcast-dest good frame immediately after -> 128 words, tuser=0.
- crs_dv dropped after 40 payload bytes -> exactly 10 words; the 10th has tlast=1, tuser=1; frame_err_count=1. The next good frame is received cleanly.
- tready held 0 for 40 cycles mid-frame -> output word held stable; overflow occurs; last word has tuser=1; no word is corrupted.
- rst_n=0 for 1 cycle mid-payload -> tvalid=0 and counters=0 the next cycle. A following good frame yields 128 words with tuser=0.
